line_clear_ctrl: RTL and testbench
==================================

// Module: line_clear_ctrl
// PURPOSE
//  Sequences the DISTROY_LINE phase. Scans the 10x20 board colour RAM bottom-up for full rows.
//  For each full row it shifts every row above it down by one and zero-fills row 0.
//  Arbitrates the single-port board RAM between the VGA pixel read path (ram_color) and itself.
//  Sits between the game FSM (start/done), the board RAM and the colour generator.
// PARAMETERS
//  COLS   10  board width in cells
//  ROWS   20  board height in cells
//  AW     8   RAM address width; address = row*COLS + col, row 0 = top
//  DW     24  cell width, RGB colour; 0 = empty cell
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset, asynchronous, active-low
//  start          in   1   one-cycle pulse from game FSM on entry to DISTROY_LINE
//  busy           out  1   high from the cycle after start is accepted until done
//  done           out  1   one-cycle pulse, sweep complete
//  lines_cleared  out  3   full rows removed in last sweep, saturates at 7, held until next start
//  disp_req       in   1   display read request (pixel inside board area)
//  disp_addr      in   AW  display read address
//  disp_data      out  DW  = ram_rdata (display data valid the cycle after disp_req)
//  ram_addr       out  AW  RAM address
//  ram_we         out  1   RAM write enable
//  ram_wdata      out DW   RAM write data
//  ram_rdata      in  DW   RAM read data, 1-cycle latency
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, lines_cleared=0, ram_we=0; internal row/col counters=0.
//  Arbitration (combinational):
//   - Display has strict priority.
//   - disp_req=1: ram_addr=disp_addr, ram_we=0.
//   - Otherwise the engine drives the port (grant=!disp_req).
//   - Engine step advances only in granted cycles; stalled cycles repeat the same op.
//   - Engine captures ram_rdata only the cycle after its own granted read (pending flag).
//  FSM:
//   - IDLE: start=1 -> SCAN with row=ROWS-1, col=0, lines_cleared<=0. start while busy is ignored.
//   - SCAN: issue read (row,col) -> CHECK.
//   - CHECK: data=0 -> row not full (remaining cells skipped).
//       - row=0: go to DONE.
//       - else: row--, col=0, go to SCAN.
//     Data !=0 and col<COLS-1: col++, go to SCAN.
//     Data !=0 and col=COLS-1: row full; lines_cleared++ (saturating), src=row, col=0.
//       - src=0: go to CLEAR.
//       - else: go to SH_RD.
//   - SH_RD: read (src-1,col) -> SH_WR.
//   - SH_WR: write ram_rdata to (src,col).
//       - col<COLS-1: col++.
//       - else: col=0, src--.
//     Go to CLEAR if src reaches 0, else SH_RD.
//   - CLEAR: write 0 to (0,col), one per granted cycle; after col=COLS-1 -> SCAN with same row, col=0.
//     The shifted-in row is re-checked at the same index.
//   - DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Timing, no contention: start sampled cycle 0; first read issued cycle 1; 2 cycles per checked cell.
//   Shift costs 2 cycles/cell; clear costs 1 cycle/cell. Empty board: done high in cycle 41.
//  Boundaries:
//   - Row 0 full: no shift, CLEAR only.
//   - Adjacent full rows: each removed on its own re-check.
//   - disp_req held high: engine stalls indefinitely, no corruption.
//   - Reset mid-sweep: immediate return to reset values. RAM is left partially shifted; the game FSM re-inits the board.
// TESTING
//  1 Empty RAM, disp_req=0, start -> done in cycle 41, lines_cleared=0, ram_we never 1.
//  2 Row19 all 0x66FF66, row18 col3=0xFF3399, rest 0 -> row19 col3=0xFF3399, all else 0, lines_cleared=1.
//  3 Rows16-19 full, row15 col0=0x9900FF -> lines_cleared=4, row19 col0=0x9900FF, rows0-18 zero.
//  4 Rows19,17 full, row18 col5=0x66B2FF -> lines_cleared=2, row19 col5=0x66B2FF only.
//  5 Case 2 with disp_req random 50% -> identical final RAM. No ram_we with disp_req=1. disp_data matches model.
//  6 Reset pulsed during SH_WR -> busy=0, done=0, ram_we=0 same cycle. Fresh start on empty RAM -> done in cycle 41.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board RAM bottom-up for full rows, shifts the rows above down
// and zero-fills row 0, sharing the single RAM port with the display, which has strict priority.
module line_clear_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int AW   = 8,
  parameter int DW   = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    lines_cleared,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [2:0]    dbg_state
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_SH_RD = 3'd3;
  localparam logic [2:0] S_SH_WR = 3'd4;
  localparam logic [2:0] S_CLEAR = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // RAM port handshake: disp_req acts as a request with implicit, unconditional acceptance;
  // the engine owns the port only when grant=1 and every engine op simply repeats until granted.
  logic          grant;
  logic [2:0]    state;
  logic [RW-1:0] row;
  logic [RW-1:0] src;
  logic [CW-1:0] col;
  logic [2:0]    lines_q;
  logic          pending;
  logic [DW-1:0] data_q;
  logic [DW-1:0] cell_data;
  logic [RW-1:0] eng_row;
  logic [AW-1:0] eng_addr;
  logic          eng_we;

  assign grant     = !disp_req;
  // Read data is live on the bus only right after our own granted read; afterwards use the copy.
  assign cell_data = pending ? ram_rdata : data_q;

  always_comb begin
    eng_row = row;
    case (state)
      S_SH_RD: eng_row = src - 1'b1;
      S_SH_WR: eng_row = src;
      S_CLEAR: eng_row = '0;
      default: eng_row = row;
    endcase
  end

  assign eng_addr  = AW'(eng_row) * AW'(COLS) + AW'(col);
  assign eng_we    = (state == S_SH_WR) || (state == S_CLEAR);
  assign ram_addr  = disp_req ? disp_addr : eng_addr;
  assign ram_we    = grant && eng_we;
  assign ram_wdata = (state == S_SH_WR) ? cell_data : '0;
  assign disp_data = ram_rdata;

  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);
  assign lines_cleared = lines_q;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      data_q  <= '0;
    end else begin
      pending <= grant && ((state == S_SCAN) || (state == S_SH_RD));
      if (pending) data_q <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      row     <= '0;
      src     <= '0;
      col     <= '0;
      lines_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SCAN;
            row     <= ROW_LAST;
            col     <= '0;
            lines_q <= '0;
          end
        end
        S_SCAN: begin
          if (grant) state <= S_CHECK;
        end
        S_CHECK: begin
          if (cell_data == '0) begin
            col <= '0;
            if (row == '0) begin
              state <= S_DONE;
            end else begin
              row   <= row - 1'b1;
              state <= S_SCAN;
            end
          end else if (col != COL_LAST) begin
            col   <= col + 1'b1;
            state <= S_SCAN;
          end else begin
            if (lines_q != 3'd7) lines_q <= lines_q + 3'd1;
            src   <= row;
            col   <= '0;
            state <= (row == '0) ? S_CLEAR : S_SH_RD;
          end
        end
        S_SH_RD: begin
          if (grant) state <= S_SH_WR;
        end
        S_SH_WR: begin
          if (grant) begin
            if (col != COL_LAST) begin
              col   <= col + 1'b1;
              state <= S_SH_RD;
            end else begin
              col   <= '0;
              src   <= src - 1'b1;
              state <= (src == RW'(1)) ? S_CLEAR : S_SH_RD;
            end
          end
        end
        S_CLEAR: begin
          if (grant) begin
            if (col == COL_LAST) begin
              col   <= '0;
              state <= S_SCAN;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: behavioural board RAM, row-removal reference model,
// directed boards plus randomized boards with random display contention.
module tb_line_clear_ctrl;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int AW    = 8;
  localparam int DW    = 24;
  localparam int CELLS = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [2:0]    lines_cleared;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [2:0]    dbg_state;

  line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_data(disp_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // single-port board RAM, 1-cycle read latency, read-before-write
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  int n_vec = 0;
  int n_miscmp = 0;
  logic [DW-1:0] brd [0:CELLS-1];
  logic [DW-1:0] exp_mem [0:CELLS-1];
  logic [2:0]    exp_lines;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_brd();
    for (int a = 0; a < CELLS; a++) brd[a] = '0;
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < COLS; c++) brd[r*COLS + c] = DW'($urandom_range(1, 24'hFFFFFF));
  endtask

  // Reference: drop every full row, stack the surviving rows at the bottom in order.
  task automatic load_and_model();
    int dst;
    int full_cnt;
    bit is_full;
    dst = ROWS - 1;
    full_cnt = 0;
    for (int a = 0; a < CELLS; a++) begin
      mem[a] = brd[a];
      exp_mem[a] = '0;
    end
    for (int r = ROWS - 1; r >= 0; r--) begin
      is_full = 1'b1;
      for (int c = 0; c < COLS; c++) if (brd[r*COLS + c] == '0) is_full = 1'b0;
      if (is_full) full_cnt++;
      else begin
        for (int c = 0; c < COLS; c++) exp_mem[dst*COLS + c] = brd[r*COLS + c];
        dst--;
      end
    end
    exp_lines = (full_cnt > 7) ? 3'd7 : 3'(full_cnt);
  endtask

  task automatic run_sweep(input bit rand_disp, output int cyc, output int we_cnt);
    bit got_done;
    bit had_req;
    logic [DW-1:0] exp_dd;
    cyc = 0;
    we_cnt = 0;
    got_done = 1'b0;
    start = 1'b1;
    disp_req = rand_disp ? 1'($urandom_range(0, 1)) : 1'b0;
    disp_addr = AW'($urandom_range(0, CELLS - 1));
    for (int i = 0; i < 30000; i++) begin
      #1;
      had_req = disp_req;
      exp_dd = mem[disp_addr];
      if (ram_we) we_cnt++;
      check("we_under_disp", {31'd0, disp_req & ram_we}, 32'd0);
      tick();
      start = 1'b0;
      cyc++;
      if (had_req) check("disp_data", disp_data, exp_dd);
      if (cyc == 1) check("busy_c1", busy, 1);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      disp_req = rand_disp ? 1'($urandom_range(0, 1)) : 1'b0;
      disp_addr = AW'($urandom_range(0, CELLS - 1));
    end
    disp_req = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string name);
    check({name, "_lines"}, lines_cleared, exp_lines);
    check({name, "_busy_at_done"}, busy, 0);
    for (int a = 0; a < CELLS; a++)
      check($sformatf("%s_cell%0d", name, a), mem[a], exp_mem[a]);
    tick();
    tick();
    check({name, "_done_pulse"}, done, 0);
    check({name, "_lines_held"}, lines_cleared, exp_lines);
  endtask

  task automatic case2_board();
    clear_brd();
    for (int c = 0; c < COLS; c++) brd[19*COLS + c] = 24'h66FF66;
    brd[18*COLS + 3] = 24'hFF3399;
  endtask

  int cyc;
  int we_cnt;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    disp_req = 1'b0;
    disp_addr = '0;
    clear_brd();
    load_and_model();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_we", ram_we, 0);
    rst = 1'b1;
    tick();

    // 1: empty board
    clear_brd();
    load_and_model();
    run_sweep(1'b0, cyc, we_cnt);
    check("t1_done_cycle", cyc, 41);
    check("t1_we_count", we_cnt, 0);
    check_result("t1");

    // 2: bottom row full, one cell above
    case2_board();
    load_and_model();
    check("t2_model_cell", exp_mem[19*COLS + 3], 24'hFF3399);
    run_sweep(1'b0, cyc, we_cnt);
    check_result("t2");

    // 3: four adjacent full rows
    clear_brd();
    for (int r = 16; r < 20; r++) fill_row(r);
    brd[15*COLS] = 24'h9900FF;
    load_and_model();
    run_sweep(1'b0, cyc, we_cnt);
    check_result("t3");

    // 4: rows 19 and 17 full with a partial row between
    clear_brd();
    fill_row(19);
    fill_row(17);
    brd[18*COLS + 5] = 24'h66B2FF;
    load_and_model();
    run_sweep(1'b0, cyc, we_cnt);
    check_result("t4");

    // 5: case 2 with random display contention
    case2_board();
    load_and_model();
    run_sweep(1'b1, cyc, we_cnt);
    check_result("t5");

    // row 0 full: clear only
    clear_brd();
    fill_row(0);
    brd[10*COLS + 7] = 24'h123456;
    load_and_model();
    run_sweep(1'b1, cyc, we_cnt);
    check_result("row0");

    // nine full rows: count saturates at 7
    clear_brd();
    for (int r = 11; r < 20; r++) fill_row(r);
    brd[10*COLS + 2] = 24'hABCDEF;
    load_and_model();
    run_sweep(1'b0, cyc, we_cnt);
    check_result("sat");

    // random boards with random contention
    for (int t = 0; t < 4; t++) begin
      clear_brd();
      for (int r = 8; r < ROWS; r++) begin
        if ($urandom_range(0, 99) < 35) fill_row(r);
        else
          for (int c = 0; c < COLS; c++)
            if ($urandom_range(0, 1) == 1) brd[r*COLS + c] = DW'($urandom_range(1, 24'hFFFFFF));
      end
      load_and_model();
      run_sweep(1'b1, cyc, we_cnt);
      check_result($sformatf("rnd%0d", t));
    end

    // 6: reset while shifting (row 19 checked by cycle 20, first write in cycle 22)
    case2_board();
    load_and_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    check("t6_pre_we", ram_we, 1);
    check("t6_pre_lines", lines_cleared, 1);
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_we", ram_we, 0);
    check("t6_lines", lines_cleared, 0);
    tick();
    rst = 1'b1;
    tick();
    clear_brd();
    load_and_model();
    run_sweep(1'b0, cyc, we_cnt);
    check("t6_done_cycle", cyc, 41);
    check_result("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
